// File: rtl/pong_pkg.sv
// Shared definitions for the Pong pixel pipeline: colour palette,
// hit-flash state encoding and the 8x8 ball disc bitmap.
package pong_pkg;

  localparam logic [11:0] COLOR_WALL      = 12'h89C;
  localparam logic [11:0] COLOR_PADDLE    = 12'h24F;
  localparam logic [11:0] COLOR_HEADER_BG = 12'h135;
  localparam logic [11:0] COLOR_SPEED3    = 12'hFF0;
  localparam logic [11:0] COLOR_SPEED4    = 12'h0F0;
  localparam logic [11:0] COLOR_SPEED5    = 12'hF00;
  localparam logic [11:0] COLOR_SPEED_DEF = 12'h135;
  localparam logic [11:0] COLOR_TRAIL     = 12'h567;

  typedef enum logic {
    ST_IDLE,
    ST_FLASH
  } flash_state_t;

  // Round disc, one byte per row; bit index within a row is the column.
  function automatic logic [7:0] ball_rom_row(input logic [2:0] row);
    logic [7:0] bits;
    case (row)
      3'd0:    bits = 8'h3C;
      3'd1:    bits = 8'h7E;
      3'd2:    bits = 8'hFF;
      3'd3:    bits = 8'hFF;
      3'd4:    bits = 8'hFF;
      3'd5:    bits = 8'hFF;
      3'd6:    bits = 8'h7E;
      default: bits = 8'h3C;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/pong_pixel_pipe_ball_hit_test.sv
// Ball bitmap hit test: is raster (x,y) on a lit pixel of a disc whose
// top-left corner is (pos_x,pos_y), scaled by BALL_SCALE (power of two).
module ball_hit_test
  import pong_pkg::*;
#(
  parameter int unsigned BALL_SCALE = 1
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  output logic       on
);

  localparam int unsigned SHIFT = $clog2(BALL_SCALE);

  logic [10:0] diff_x, diff_y;
  logic [9:0]  cell_x, cell_y;
  logic        in_x, in_y;
  logic [7:0]  row_bits;

  // Window test folded into the subtraction: no borrow means x >= pos_x,
  // and the scaled offset must fit in 3 bits to lie inside the square.
  always_comb begin
    diff_x   = {1'b0, x} - {1'b0, pos_x};
    diff_y   = {1'b0, y} - {1'b0, pos_y};
    cell_x   = diff_x[9:0] >> SHIFT;
    cell_y   = diff_y[9:0] >> SHIFT;
    in_x     = !diff_x[10] && (cell_x[9:3] == '0);
    in_y     = !diff_y[10] && (cell_y[9:3] == '0);
    row_bits = ball_rom_row(cell_y[2:0]);
    on       = in_x && in_y && row_bits[cell_x[2:0]];
  end

endmodule

// File: rtl/pong_pixel_pipe.sv
// Pong pixel colour pipeline: two pix_tick-gated stages from raster
// position to registered RGB, plus a frame-counted ball hit-flash FSM.
// Optional feature macro: BALL_TRAIL_EN (4-deep ball position trail).
module pong_pixel_pipe
  import pong_pkg::*;
#(
  parameter int unsigned H_RES        = 640,
  parameter int unsigned WALL_W       = 32,
  parameter int unsigned PADDLE_W     = 9,
  parameter int unsigned PADDLE_H     = 73,
  parameter int unsigned TOP_MARGIN   = 25,
  parameter int unsigned BALL_SCALE   = 1,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter logic [11:0] FLASH_COLOR  = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_tick,
  input  logic        frame_start,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [9:0]  paddle1_y,
  input  logic [9:0]  paddle2_y,
  input  logic [3:0]  ball_speed,
  input  logic        hit_pulse,
  input  logic        game_over,
  input  logic [11:0] bg_pixel,
  input  logic [11:0] game_over_pixel,
  input  logic [11:0] text_rgb,
  input  logic        text_on,
  output logic [11:0] rgb,
  output logic        video_on_q
);

  localparam logic [10:0] TOP_M     = 11'(TOP_MARGIN);
  localparam logic [10:0] LWALL_END = 11'(WALL_W);
  localparam logic [10:0] RWALL_X   = 11'(H_RES - WALL_W);
  localparam logic [10:0] PAD1_X_LO = 11'(WALL_W);
  localparam logic [10:0] PAD1_X_HI = 11'(WALL_W + PADDLE_W - 1);
  localparam logic [10:0] PAD2_X_LO = 11'(H_RES - WALL_W - PADDLE_W);
  localparam logic [10:0] PAD2_X_HI = 11'(H_RES - WALL_W - 1);
  localparam logic [10:0] PAD_SPAN  = 11'(PADDLE_H - 1);
  localparam logic [7:0]  FLASH_LD  = 8'(FLASH_FRAMES);

  // ---------------- flash FSM ----------------
  flash_state_t state;
  logic [7:0]   flash_cnt;

  // Hit flash counted in frames; game_over overrides, reload beats frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      flash_cnt <= '0;
    end else if (game_over) begin
      state     <= ST_IDLE;
      flash_cnt <= '0;
    end else if (hit_pulse) begin
      state     <= ST_FLASH;
      flash_cnt <= FLASH_LD;
    end else if (state == ST_FLASH && frame_start) begin
      if (flash_cnt == 8'd1) begin
        state     <= ST_IDLE;
        flash_cnt <= '0;
      end else begin
        flash_cnt <= flash_cnt - 8'd1;
      end
    end
  end

  // ---------------- region decode ----------------
  logic [10:0] x_w, y_w;
  logic [10:0] pad1_top, pad1_bot, pad2_top, pad2_bot;
  logic        header_c, lwall_c, rwall_c, pad1_c, pad2_c;
  logic [11:0] ball_rgb_c;
  logic        ball_c;

  // Geometry compares in 11 bits so large paddle positions never wrap.
  always_comb begin
    x_w      = {1'b0, x};
    y_w      = {1'b0, y};
    pad1_top = {1'b0, paddle1_y} + TOP_M;
    pad1_bot = pad1_top + PAD_SPAN;
    pad2_top = {1'b0, paddle2_y} + TOP_M;
    pad2_bot = pad2_top + PAD_SPAN;
    header_c = y_w < TOP_M;
    lwall_c  = x_w < LWALL_END;
    rwall_c  = x_w >= RWALL_X;
    pad1_c   = (x_w >= PAD1_X_LO) && (x_w <= PAD1_X_HI) &&
               (y_w >= pad1_top) && (y_w <= pad1_bot);
    pad2_c   = (x_w >= PAD2_X_LO) && (x_w <= PAD2_X_HI) &&
               (y_w >= pad2_top) && (y_w <= pad2_bot);
  end

  // Ball colour: flash overrides the speed palette.
  always_comb begin
    ball_rgb_c = COLOR_SPEED_DEF;
    if (state == ST_FLASH) begin
      ball_rgb_c = FLASH_COLOR;
    end else begin
      case (ball_speed)
        4'd3:    ball_rgb_c = COLOR_SPEED3;
        4'd4:    ball_rgb_c = COLOR_SPEED4;
        4'd5:    ball_rgb_c = COLOR_SPEED5;
        default: ball_rgb_c = COLOR_SPEED_DEF;
      endcase
    end
  end

  ball_hit_test #(.BALL_SCALE(BALL_SCALE)) u_ball_hit (
    .x     (x),
    .y     (y),
    .pos_x (ball_x),
    .pos_y (ball_y),
    .on    (ball_c)
  );

`ifdef BALL_TRAIL_EN
  // ---------------- ball trail ----------------
  logic [9:0] trail_x [4];
  logic [9:0] trail_y [4];
  logic [3:0] trail_valid;
  logic [3:0] trail_hit;
  logic       trail_c;

  // Position history shifted once per frame, newest in entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        trail_x[i] <= '0;
        trail_y[i] <= '0;
      end
      trail_valid <= '0;
    end else begin
      if (frame_start) begin
        trail_x[0] <= ball_x;
        trail_y[0] <= ball_y;
        for (int unsigned i = 1; i < 4; i++) begin
          trail_x[i] <= trail_x[i-1];
          trail_y[i] <= trail_y[i-1];
        end
      end
      if (game_over)
        trail_valid <= '0;
      else if (frame_start)
        trail_valid <= {trail_valid[2:0], 1'b1};
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_trail
    ball_hit_test #(.BALL_SCALE(BALL_SCALE)) u_trail_hit (
      .x     (x),
      .y     (y),
      .pos_x (trail_x[g]),
      .pos_y (trail_y[g]),
      .on    (trail_hit[g])
    );
  end

  assign trail_c = |(trail_hit & trail_valid);
`endif

  // ---------------- stage 1 ----------------
  logic        s1_header, s1_lwall, s1_rwall, s1_pad1, s1_pad2, s1_ball;
  logic        s1_video_on, s1_game_over, s1_text_on;
  logic [11:0] s1_bg, s1_go_pix, s1_text_rgb, s1_ball_rgb;
`ifdef BALL_TRAIL_EN
  logic        s1_trail;
`endif

  // Capture region flags and pixel sources once per pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_header    <= 1'b0;
      s1_lwall     <= 1'b0;
      s1_rwall     <= 1'b0;
      s1_pad1      <= 1'b0;
      s1_pad2      <= 1'b0;
      s1_ball      <= 1'b0;
      s1_video_on  <= 1'b0;
      s1_game_over <= 1'b0;
      s1_text_on   <= 1'b0;
      s1_bg        <= '0;
      s1_go_pix    <= '0;
      s1_text_rgb  <= '0;
      s1_ball_rgb  <= '0;
`ifdef BALL_TRAIL_EN
      s1_trail     <= 1'b0;
`endif
    end else if (pix_tick) begin
      s1_header    <= header_c;
      s1_lwall     <= lwall_c;
      s1_rwall     <= rwall_c;
      s1_pad1      <= pad1_c;
      s1_pad2      <= pad2_c;
      s1_ball      <= ball_c;
      s1_video_on  <= video_on;
      s1_game_over <= game_over;
      s1_text_on   <= text_on;
      s1_bg        <= bg_pixel;
      s1_go_pix    <= game_over_pixel;
      s1_text_rgb  <= text_rgb;
      s1_ball_rgb  <= ball_rgb_c;
`ifdef BALL_TRAIL_EN
      s1_trail     <= trail_c;
`endif
    end
  end

  // ---------------- stage 2 ----------------
  logic [11:0] rgb_next;

  // Layer priority: blanking, game over, header, wall, paddle, ball, (trail), bg.
  always_comb begin
    rgb_next = s1_bg;
    if (!s1_video_on)
      rgb_next = '0;
    else if (s1_game_over)
      rgb_next = s1_go_pix;
    else if (s1_header)
      rgb_next = s1_text_on ? s1_text_rgb : COLOR_HEADER_BG;
    else if (s1_lwall || s1_rwall)
      rgb_next = COLOR_WALL;
    else if (s1_pad1 || s1_pad2)
      rgb_next = COLOR_PADDLE;
    else if (s1_ball)
      rgb_next = s1_ball_rgb;
`ifdef BALL_TRAIL_EN
    else if (s1_trail)
      rgb_next = COLOR_TRAIL;
`endif
  end

  // Output register, advanced with the pixel rate.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb        <= '0;
      video_on_q <= 1'b0;
    end else if (pix_tick) begin
      rgb        <= rgb_next;
      video_on_q <= s1_video_on;
    end
  end

endmodule

// File: tb/tb_pong_pixel_pipe.sv
// Directed self-checking bench for pong_pixel_pipe (default and BALL_SCALE=2).
module tb_pong_pixel_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_tick;
  logic        frame_start;
  logic [9:0]  x, y;
  logic        video_on;
  logic [9:0]  ball_x, ball_y;
  logic [9:0]  paddle1_y, paddle2_y;
  logic [3:0]  ball_speed;
  logic        hit_pulse;
  logic        game_over;
  logic [11:0] bg_pixel, game_over_pixel, text_rgb;
  logic        text_on;
  logic [11:0] rgb, rgb_s2;
  logic        video_on_q, video_on_q_s2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pong_pixel_pipe dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .frame_start(frame_start),
    .x(x), .y(y), .video_on(video_on), .ball_x(ball_x), .ball_y(ball_y),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y), .ball_speed(ball_speed),
    .hit_pulse(hit_pulse), .game_over(game_over), .bg_pixel(bg_pixel),
    .game_over_pixel(game_over_pixel), .text_rgb(text_rgb), .text_on(text_on),
    .rgb(rgb), .video_on_q(video_on_q)
  );

  pong_pixel_pipe #(.BALL_SCALE(2)) dut_s2 (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .frame_start(frame_start),
    .x(x), .y(y), .video_on(video_on), .ball_x(ball_x), .ball_y(ball_y),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y), .ball_speed(ball_speed),
    .hit_pulse(hit_pulse), .game_over(game_over), .bg_pixel(bg_pixel),
    .game_over_pixel(game_over_pixel), .text_rgb(text_rgb), .text_on(text_on),
    .rgb(rgb_s2), .video_on_q(video_on_q_s2)
  );

  localparam logic [11:0] BG = 12'h321;

  task automatic settle();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_hit();
    hit_pulse = 1'b1;
    @(negedge clk);
    hit_pulse = 1'b0;
    settle();
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_tick = 1'b1; frame_start = 1'b0; hit_pulse = 1'b0;
    video_on = 1'b1; x = 10'd20; y = 10'd100;
    ball_x = 10'd100; ball_y = 10'd100; paddle1_y = 10'd1000; paddle2_y = 10'd1000;
    ball_speed = 4'd4; game_over = 1'b0; bg_pixel = BG; game_over_pixel = 12'hABC;
    text_rgb = 12'hE0E; text_on = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
    total++; if (video_on_q !== 1'b0) begin bad++; $display("FAIL reset_vq got=%b exp=0", video_on_q); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL reset_lat1 got=%h exp=000", rgb); end
    @(negedge clk);
    total++; if (rgb !== 12'h89C) begin bad++; $display("FAIL reset_lat2 got=%h exp=89C", rgb); end
    total++; if (video_on_q !== 1'b1) begin bad++; $display("FAIL reset_vq2 got=%b exp=1", video_on_q); end
  endtask

  task automatic test_priority();
    x = 10'd620; y = 10'd200; settle();
    total++; if (rgb !== 12'h89C) begin bad++; $display("FAIL rwall got=%h exp=89C", rgb); end
    x = 10'd300; y = 10'd10; text_on = 1'b0; settle();
    total++; if (rgb !== 12'h135) begin bad++; $display("FAIL header_bg got=%h exp=135", rgb); end
    text_on = 1'b1; settle();
    total++; if (rgb !== 12'hE0E) begin bad++; $display("FAIL header_text got=%h exp=E0E", rgb); end
    text_on = 1'b0; x = 10'd300; y = 10'd300; settle();
    total++; if (rgb !== BG) begin bad++; $display("FAIL bg got=%h exp=%h", rgb, BG); end
    x = 10'd20; game_over = 1'b1; settle();
    total++; if (rgb !== 12'hABC) begin bad++; $display("FAIL game_over got=%h exp=ABC", rgb); end
    game_over = 1'b0; video_on = 1'b0; settle();
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL blank got=%h exp=000", rgb); end
    total++; if (video_on_q !== 1'b0) begin bad++; $display("FAIL blank_vq got=%b exp=0", video_on_q); end
    video_on = 1'b1;
  endtask

  task automatic test_paddle();
    paddle1_y = 10'd0; x = 10'd32; y = 10'd25; settle();
    total++; if (rgb !== 12'h24F) begin bad++; $display("FAIL pad1_top got=%h exp=24F", rgb); end
    y = 10'd97; settle();
    total++; if (rgb !== 12'h24F) begin bad++; $display("FAIL pad1_last got=%h exp=24F", rgb); end
    y = 10'd98; settle();
    total++; if (rgb !== BG) begin bad++; $display("FAIL pad1_below got=%h exp=%h", rgb, BG); end
    x = 10'd41; y = 10'd50; settle();
    total++; if (rgb !== BG) begin bad++; $display("FAIL pad1_right got=%h exp=%h", rgb, BG); end
    paddle2_y = 10'd100; x = 10'd599; y = 10'd125; settle();
    total++; if (rgb !== 12'h24F) begin bad++; $display("FAIL pad2 got=%h exp=24F", rgb); end
    paddle1_y = 10'd1000; x = 10'd32; y = 10'd0; settle();
    total++; if (rgb !== 12'h135) begin bad++; $display("FAIL pad1_nowrap_hdr got=%h exp=135", rgb); end
    y = 10'd30; settle();
    total++; if (rgb !== BG) begin bad++; $display("FAIL pad1_nowrap got=%h exp=%h", rgb, BG); end
    paddle2_y = 10'd1000;
  endtask

  task automatic test_ball();
    x = 10'd100; y = 10'd100; settle();
    total++; if (rgb !== BG) begin bad++; $display("FAIL ball_corner got=%h exp=%h", rgb, BG); end
    x = 10'd103; settle();
    total++; if (rgb !== 12'h0F0) begin bad++; $display("FAIL ball_speed4 got=%h exp=0F0", rgb); end
    ball_speed = 4'd3; settle();
    total++; if (rgb !== 12'hFF0) begin bad++; $display("FAIL ball_speed3 got=%h exp=FF0", rgb); end
    ball_speed = 4'd5; settle();
    total++; if (rgb !== 12'hF00) begin bad++; $display("FAIL ball_speed5 got=%h exp=F00", rgb); end
    ball_speed = 4'd9; settle();
    total++; if (rgb !== 12'h135) begin bad++; $display("FAIL ball_speed9 got=%h exp=135", rgb); end
    ball_speed = 4'd4; x = 10'd108; settle();
    total++; if (rgb !== BG) begin bad++; $display("FAIL ball_outside got=%h exp=%h", rgb, BG); end
  endtask

  task automatic test_ball_scale2();
    x = 10'd115; y = 10'd107; settle();
    total++; if (rgb_s2 !== 12'h0F0) begin bad++; $display("FAIL scale2_on got=%h exp=0F0", rgb_s2); end
    total++; if (rgb !== BG) begin bad++; $display("FAIL scale1_off got=%h exp=%h", rgb, BG); end
    x = 10'd101; y = 10'd101; settle();
    total++; if (rgb_s2 !== BG) begin bad++; $display("FAIL scale2_corner got=%h exp=%h", rgb_s2, BG); end
    x = 10'd103; y = 10'd100;
  endtask

  task automatic test_flash();
    x = 10'd103; y = 10'd100;
    pulse_hit();
    total++; if (rgb !== 12'hFFF) begin bad++; $display("FAIL flash_start got=%h exp=FFF", rgb); end
    for (int i = 1; i <= 8; i++) begin
      pulse_frame();
      total++;
      if (rgb !== ((i < 8) ? 12'hFFF : 12'h0F0)) begin
        bad++; $display("FAIL flash_frame%0d got=%h exp=%h", i, rgb, (i < 8) ? 12'hFFF : 12'h0F0);
      end
    end
  endtask

  task automatic test_flash_reload();
    pulse_hit();
    for (int i = 1; i <= 5; i++) pulse_frame();
    total++; if (rgb !== 12'hFFF) begin bad++; $display("FAIL reload_pre got=%h exp=FFF", rgb); end
    pulse_hit();
    for (int i = 6; i <= 13; i++) begin
      pulse_frame();
      total++;
      if (rgb !== ((i < 13) ? 12'hFFF : 12'h0F0)) begin
        bad++; $display("FAIL reload_frame%0d got=%h exp=%h", i, rgb, (i < 13) ? 12'hFFF : 12'h0F0);
      end
    end
    // hit and frame_start together: reload wins, so 7 more frames still flash
    pulse_hit();
    hit_pulse = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    hit_pulse = 1'b0; frame_start = 1'b0;
    for (int i = 1; i <= 7; i++) pulse_frame();
    total++; if (rgb !== 12'hFFF) begin bad++; $display("FAIL reload_same got=%h exp=FFF", rgb); end
    pulse_frame();
    total++; if (rgb !== 12'h0F0) begin bad++; $display("FAIL reload_same_end got=%h exp=0F0", rgb); end
  endtask

  task automatic test_game_over_flash();
    pulse_hit();
    total++; if (rgb !== 12'hFFF) begin bad++; $display("FAIL go_flash got=%h exp=FFF", rgb); end
    game_over = 1'b1; settle();
    total++; if (rgb !== 12'hABC) begin bad++; $display("FAIL go_pixel got=%h exp=ABC", rgb); end
    game_over = 1'b0; settle();
    total++; if (rgb !== 12'h0F0) begin bad++; $display("FAIL go_idle got=%h exp=0F0", rgb); end
  endtask

  task automatic test_pix_tick_hold();
    x = 10'd20; y = 10'd200; settle();
    total++; if (rgb !== 12'h89C) begin bad++; $display("FAIL hold_pre got=%h exp=89C", rgb); end
    pix_tick = 1'b0; x = 10'd300; video_on = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (rgb !== 12'h89C || video_on_q !== 1'b1) begin
        bad++; $display("FAIL hold_clk%0d got=%h/%b exp=89C/1", i, rgb, video_on_q);
      end
    end
    pix_tick = 1'b1; settle();
    total++; if (rgb !== 12'h000 || video_on_q !== 1'b0) begin
      bad++; $display("FAIL hold_resume got=%h/%b exp=000/0", rgb, video_on_q);
    end
    video_on = 1'b1;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_paddle();
    test_ball();
    test_ball_scale2();
    test_flash();
    test_flash_reload();
    test_game_over_flash();
    test_pix_tick_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
